// File: rtl/conv_mac_core_if.sv
// Sample/coefficient/result bundle for conv_mac_core.
// The master side drives window slices and coefficient updates; the slave side is the core.
interface conv_mac_core_if #(
    parameter int N  = 3,
    parameter int DW = 9,
    parameter int KW = 3,
    parameter int OW = 16
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic [N*DW-1:0]        data;
    logic                   data_de;
    logic                   abs_en;
    logic                   k_we;
    logic [AW-1:0]          k_addr;
    logic signed [KW-1:0]   k_data;
    logic                   k_commit;
    logic                   k_pending;
    logic signed [OW-1:0]   res;
    logic                   res_de;
    logic                   res_sat;

    modport master (
        output data, data_de, abs_en, k_we, k_addr, k_data, k_commit,
        input  k_pending, res, res_de, res_sat
    );

    modport slave (
        input  data, data_de, abs_en, k_we, k_addr, k_data, k_commit,
        output k_pending, res, res_de, res_sat
    );
endinterface

// File: rtl/conv_mac_core.sv
// N-tap signed multiply-accumulate core: registered products, registered binary
// adder tree, then optional |x|, round-half-up shift and saturation.
// Coefficients are written to a shadow bank and copied to the active bank only
// on a cycle with data_de low, so a burst always sees one coherent set.
module conv_mac_core #(
    parameter int N     = 3,
    parameter int DW    = 9,
    parameter int KW    = 3,
    parameter int OW    = 16,
    parameter int SHIFT = 0
) (
    input logic              clk,
    input logic              rst_n,
    conv_mac_core_if.slave   bus
);
    localparam int LV = (N > 1) ? $clog2(N) : 0;
    localparam int NP = 1 << LV;
    localparam int PW = DW + KW;
    localparam int SW = PW + LV;
    localparam int L  = LV + 2;
    // Wide enough for |sum| plus rounding, and always wider than OW so the
    // saturation compare is exact.
    localparam int WW = ((SW + 2 > OW) ? SW + 2 : OW) + 1;

    localparam logic signed [WW-1:0] RND  = (SHIFT > 0) ? (WW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [WW-1:0] SMAX = {{(WW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [WW-1:0] SMIN = {{(WW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [DW-1:0] tap          [N];
    logic signed [KW-1:0] k_shadow     [N];
    logic signed [KW-1:0] k_shadow_nxt [N];
    logic signed [KW-1:0] k_active     [N];
    logic                 pending;
    logic                 commit_go;

    // Heap-ordered tree: node[0] is the root, leaves sit at NP-1 .. 2*NP-2.
    logic signed [SW-1:0] node [2*NP-1];

    logic [L-2:0]         de_sr;
    logic [L-2:0]         abs_sr;

    logic signed [SW:0]   sum_ext;
    logic signed [SW:0]   mag;
    logic signed [WW-1:0] wide;
    logic signed [WW-1:0] rounded;
    logic                 over;
    logic                 under;
    logic signed [OW-1:0] sat_val;

    for (genvar i = 0; i < N; i++) begin : g_tap
        assign tap[i] = bus.data[i*DW +: DW];
    end

    // Shadow bank including this cycle's write, so a same-cycle commit sees it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            k_shadow_nxt[i] = k_shadow[i];
            if (bus.k_we && (int'(bus.k_addr) == i)) begin
                k_shadow_nxt[i] = bus.k_data;
            end
        end
    end

    assign commit_go = (pending | bus.k_commit) & ~bus.data_de;

    // Coefficient banks and pending-commit flag; commits only land while data_de is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                k_shadow[i] <= '0;
                k_active[i] <= '0;
            end
            pending <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                k_shadow[i] <= k_shadow_nxt[i];
            end
            if (commit_go) begin
                for (int i = 0; i < N; i++) begin
                    k_active[i] <= k_shadow_nxt[i];
                end
                pending <= 1'b0;
            end else if (bus.k_commit) begin
                pending <= 1'b1;
            end
        end
    end

    assign bus.k_pending = pending;

    for (genvar i = 0; i < NP; i++) begin : g_leaf
        if (i < N) begin : g_mul
            // Product register for one tap; idle slots carry zero into the tree.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    node[NP-1+i] <= '0;
                end else if (bus.data_de) begin
                    node[NP-1+i] <= SW'(tap[i]) * SW'(k_active[i]);
                end else begin
                    node[NP-1+i] <= '0;
                end
            end
        end else begin : g_pad
            // Padding leaf for non-power-of-two N; the lone operand then passes through as x+0.
            always_ff @(posedge clk) begin
                node[NP-1+i] <= '0;
            end
        end
    end

    for (genvar k = 0; k < NP - 1; k++) begin : g_add
        // One registered adder of the tree, full SW precision.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                node[k] <= '0;
            end else begin
                node[k] <= node[2*k+1] + node[2*k+2];
            end
        end
    end

    // Valid and abs-mode flags travel alongside the samples up to the output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_sr  <= '0;
            abs_sr <= '0;
        end else begin
            de_sr[0]  <= bus.data_de;
            abs_sr[0] <= bus.abs_en;
            for (int j = 1; j < L - 1; j++) begin
                de_sr[j]  <= de_sr[j-1];
                abs_sr[j] <= abs_sr[j-1];
            end
        end
    end

    // Post-processing: |sum|, round-half-up arithmetic shift, saturate.
    always_comb begin
        sum_ext = {node[0][SW-1], node[0]};
        mag     = sum_ext;
        if (abs_sr[L-2] && sum_ext[SW]) begin
            mag = -sum_ext;
        end
        wide    = WW'(mag);
        rounded = (wide + RND) >>> SHIFT;
        over    = (rounded > SMAX);
        under   = (rounded < SMIN);
        sat_val = rounded[OW-1:0];
        if (over) begin
            sat_val = SMAX[OW-1:0];
        end else if (under) begin
            sat_val = SMIN[OW-1:0];
        end
    end

    // Output register; data and saturation flag are held at zero when not valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.res     <= '0;
            bus.res_de  <= 1'b0;
            bus.res_sat <= 1'b0;
        end else begin
            bus.res_de  <= de_sr[L-2];
            bus.res     <= de_sr[L-2] ? sat_val : '0;
            bus.res_sat <= de_sr[L-2] & (over | under);
        end
    end
endmodule

// File: tb/tb_conv_mac_core.sv
// Bench for conv_mac_core: three instances (default, OW=8, SHIFT=2) share one
// stimulus stream; each is compared every cycle against an arithmetic reference.
module tb_conv_mac_core;
    localparam int N  = 3;
    localparam int DW = 9;
    localparam int KW = 3;
    localparam int L  = 4;

    typedef struct {
        bit     de;
        longint val;
        bit     sat;
    } exp_t;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N*DW-1:0]      s_data   = '0;
    logic                 s_de     = 1'b0;
    logic                 s_abs    = 1'b0;
    logic                 s_kwe    = 1'b0;
    logic [1:0]           s_kaddr  = '0;
    logic signed [KW-1:0] s_kdata  = '0;
    logic                 s_kcommit = 1'b0;

    int     n_assert = 0;
    int     n_fail   = 0;
    int     tap_v    [N];
    int     m_shadow [N];
    int     m_active [N];
    bit     m_pend;
    exp_t   q0[$], q1[$], q2[$];
    exp_t   e0, e1, e2;

    always #5 clk = ~clk;

    conv_mac_core_if #(.N(N), .DW(DW), .KW(KW), .OW(16)) b0 ();
    conv_mac_core_if #(.N(N), .DW(DW), .KW(KW), .OW(8))  b1 ();
    conv_mac_core_if #(.N(N), .DW(DW), .KW(KW), .OW(16)) b2 ();

    assign b0.data = s_data;   assign b1.data = s_data;   assign b2.data = s_data;
    assign b0.data_de = s_de;  assign b1.data_de = s_de;  assign b2.data_de = s_de;
    assign b0.abs_en = s_abs;  assign b1.abs_en = s_abs;  assign b2.abs_en = s_abs;
    assign b0.k_we = s_kwe;    assign b1.k_we = s_kwe;    assign b2.k_we = s_kwe;
    assign b0.k_addr = s_kaddr; assign b1.k_addr = s_kaddr; assign b2.k_addr = s_kaddr;
    assign b0.k_data = s_kdata; assign b1.k_data = s_kdata; assign b2.k_data = s_kdata;
    assign b0.k_commit = s_kcommit; assign b1.k_commit = s_kcommit; assign b2.k_commit = s_kcommit;

    conv_mac_core #(.N(N), .DW(DW), .KW(KW), .OW(16), .SHIFT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    conv_mac_core #(.N(N), .DW(DW), .KW(KW), .OW(8),  .SHIFT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    conv_mac_core #(.N(N), .DW(DW), .KW(KW), .OW(16), .SHIFT(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: dot product, optional |x|, divide by 2^sh rounding half up, clamp to ow bits.
    function automatic exp_t predict(input longint sum, input bit absf, input int ow, input int sh);
        exp_t   r;
        longint v, d, q, hi, lo;
        v = (absf && sum < 0) ? -sum : sum;
        if (sh > 0) begin
            d = longint'(1) << sh;
            v = v + d / 2;
            q = v / d;
            if ((v % d) != 0 && v < 0) q = q - 1;
            v = q;
        end
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -(longint'(1) << (ow - 1));
        r.de  = 1'b1;
        r.sat = 1'b0;
        if (v > hi) begin
            v = hi; r.sat = 1'b1;
        end else if (v < lo) begin
            v = lo; r.sat = 1'b1;
        end
        r.val = v;
        return r;
    endfunction

    task automatic model_edge();
        exp_t   inv;
        longint sum;
        inv = '{de: 1'b0, val: 0, sat: 1'b0};
        if (!rst_n) begin
            q0.delete(); q1.delete(); q2.delete();
            for (int i = 0; i < L; i++) begin
                q0.push_back(inv); q1.push_back(inv); q2.push_back(inv);
            end
            for (int i = 0; i < N; i++) begin
                m_shadow[i] = 0; m_active[i] = 0;
            end
            m_pend = 1'b0;
        end else begin
            sum = 0;
            for (int i = 0; i < N; i++) sum += longint'(tap_v[i]) * longint'(m_active[i]);
            q0.push_back(s_de ? predict(sum, s_abs, 16, 0) : inv);
            q1.push_back(s_de ? predict(sum, s_abs, 8, 0)  : inv);
            q2.push_back(s_de ? predict(sum, s_abs, 16, 2) : inv);
            if (s_kwe && s_kaddr < N) m_shadow[s_kaddr] = int'(s_kdata);
            if ((m_pend || s_kcommit) && !s_de) begin
                for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
                m_pend = 1'b0;
            end else if (s_kcommit) begin
                m_pend = 1'b1;
            end
        end
        e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("de0", b0.res_de, e0.de);   check("res0", b0.res, e0.val);   check("sat0", b0.res_sat, e0.sat);
        check("de1", b1.res_de, e1.de);   check("res1", b1.res, e1.val);   check("sat1", b1.res_sat, e1.sat);
        check("de2", b2.res_de, e2.de);   check("res2", b2.res, e2.val);   check("sat2", b2.res_sat, e2.sat);
        check("pend0", b0.k_pending, m_pend);
        check("pend1", b1.k_pending, m_pend);
        check("pend2", b2.k_pending, m_pend);
    endtask

    task automatic put(input int d0, input int d1, input int d2, input bit de, input bit absf);
        tap_v[0] = d0; tap_v[1] = d1; tap_v[2] = d2;
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = tap_v[i][DW-1:0];
        s_de  = de;
        s_abs = absf;
    endtask

    task automatic idle();
        s_de  = 1'b0;
        s_abs = 1'b0;
    endtask

    task automatic wr_k(input int a, input int v);
        s_kwe   = 1'b1;
        s_kaddr = a[1:0];
        s_kdata = v[KW-1:0];
        step();
        s_kwe   = 1'b0;
    endtask

    task automatic set_k(input int k0, input int k1, input int k2);
        wr_k(0, k0); wr_k(1, k1); wr_k(2, k2);
        s_kcommit = 1'b1;
        step();
        s_kcommit = 1'b0;
    endtask

    initial begin
        int r;
        put(0, 0, 0, 1'b0, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_res", b0.res, 0);
        check("rst_pend", b0.k_pending, 0);

        // Basic dot product and latency
        set_k(-1, 0, 1);
        put(100, 50, 20, 1'b1, 1'b0); step(); idle();
        repeat (2) step();
        check("lat_early_de", b0.res_de, 0);
        step();
        check("basic_val", b0.res, -80);
        check("basic_de", b0.res_de, 1);
        check("basic_sat", b0.res_sat, 0);
        check("basic_shift", b2.res, -20);

        // Absolute-value mode
        put(100, 50, 20, 1'b1, 1'b1); step(); idle();
        repeat (3) step();
        check("abs_val", b0.res, 80);

        // Back-to-back burst, alternating abs mode
        for (int i = 0; i < 10; i++) begin
            put(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                int'($urandom_range(0, 511)) - 256, 1'b1, 1'(i % 2));
            step();
        end
        idle();
        repeat (L) step();

        // Saturation (OW=8 instance)
        set_k(3, 3, 3);
        put(-256, -256, -256, 1'b1, 1'b0); step();
        put(255, 255, 255, 1'b1, 1'b0); step();
        idle(); step(); step();
        check("sat_neg_val", b1.res, -128);
        check("sat_neg_flag", b1.res_sat, 1);
        check("nosat_full", b0.res, -2304);
        step();
        check("sat_pos_val", b1.res, 127);
        check("sat_pos_flag", b1.res_sat, 1);

        // Rounding shift (SHIFT=2 instance)
        set_k(1, 1, 1);
        put(3, 2, 0, 1'b1, 1'b0); step();
        put(3, 3, 0, 1'b1, 1'b0); step();
        idle(); step(); step();
        check("rnd_down", b2.res, 1);
        step();
        check("rnd_half_up", b2.res, 2);
        repeat (L) step();

        // Commit requested mid-burst waits for the first idle cycle
        for (int i = 0; i < 8; i++) begin
            put(1, 1, 1, 1'b1, 1'b0);
            s_kwe = 1'b0; s_kcommit = 1'b0;
            if (i >= 1 && i <= 3) begin
                s_kwe = 1'b1; s_kaddr = 2'(i - 1); s_kdata = 3'sd2;
            end
            if (i == 3) s_kcommit = 1'b1;
            step();
            if (i >= 3) begin
                check("cb_pend_hold", b0.k_pending, 1);
                check("cb_old_k", b0.res, 3);
            end
        end
        s_kwe = 1'b0; s_kcommit = 1'b0;
        idle(); step();
        check("cb_pend_clear", b0.k_pending, 0);
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            put(1, 1, 1, 1'b1, 1'b0); step();
        end
        idle(); step();
        check("cb_new_k", b0.res, 6);
        repeat (L) step();

        // Random traffic with coefficient updates and commits interleaved
        for (int i = 0; i < 300; i++) begin
            put(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                int'($urandom_range(0, 511)) - 256, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            s_kwe     = ($urandom_range(0, 7) == 0);
            s_kaddr   = 2'($urandom_range(0, 3));
            r         = int'($urandom_range(0, 7)) - 4;
            s_kdata   = r[KW-1:0];
            s_kcommit = ($urandom_range(0, 15) == 0);
            step();
        end
        s_kwe = 1'b0; s_kcommit = 1'b0;
        idle();
        repeat (L + 2) step();
        set_k(2, 2, 2);

        // Reset in the middle of a burst with a commit pending
        for (int i = 0; i < 8; i++) begin
            put(1, 1, 1, 1'b1, 1'b0);
            s_kcommit = (i == 0);
            rst_n     = (i != 2);
            step();
            if (i == 0) check("mr_pend_set", b0.k_pending, 1);
            if (i == 2) check("mr_pend_clr", b0.k_pending, 0);
            if (i >= 2 && i < 2 + L) check("mr_de_low", b0.res_de, 0);
            if (i == 2 + L) begin
                check("mr_de_back", b0.res_de, 1);
                check("mr_k_zero", b0.res, 0);
            end
        end
        rst_n = 1'b1; s_kcommit = 1'b0;
        idle();
        repeat (L) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
